// File: rtl/ifu_pkg.sv
// Shared widths, reset/NOP defaults and the fetch buffer entry layout for the
// instruction fetch unit.
package ifu_pkg;

   localparam int unsigned PORT_ADDR_WIDTH = 32;
   localparam int unsigned PORT_DATA_WIDTH = 32;
   localparam logic [PORT_ADDR_WIDTH-1:0] RESET_PC_ADDR = 32'h0000_0000;
   localparam logic [PORT_DATA_WIDTH-1:0] INST_NOP      = 32'h0000_0013;

   typedef struct packed {
      logic [PORT_ADDR_WIDTH-1:0] pc;
      logic [PORT_DATA_WIDTH-1:0] inst;
   } fetch_entry_t;

   localparam int unsigned ENTRY_WIDTH = $bits(fetch_entry_t);

   // Next sequential PC; 32'hFFFF_FFFC + 4 wraps to 0 through natural overflow.
   function automatic logic [PORT_ADDR_WIDTH-1:0] pc_incr(
      input logic [PORT_ADDR_WIDTH-1:0] pc
   );
      return pc + 32'd4;
   endfunction

   function automatic logic [PORT_ADDR_WIDTH-1:0] word_align(
      input logic [PORT_ADDR_WIDTH-1:0] addr
   );
      return addr & ~32'h0000_0003;
   endfunction

endpackage

// File: rtl/ifu_fifo.sv
// Two-entry fetch buffer between the PC/ROM stage and decode; flush discards
// all entries and outranks push/pop.
module ifu_fifo #(
   parameter int unsigned WIDTH = 64
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push_i,
   input  logic             pop_i,
   input  logic             flush_i,
   input  logic [WIDTH-1:0] data_i,
   output logic             full_o,
   output logic             empty_o,
   output logic [WIDTH-1:0] head_o
);

   logic [WIDTH-1:0] mem_q [2];
   logic [WIDTH-1:0] mem_d [2];
   logic             wr_ptr_q, wr_ptr_d;
   logic             rd_ptr_q, rd_ptr_d;
   logic [1:0]       count_q, count_d;
   logic             push_ok, pop_ok;

   assign full_o  = (count_q == 2'd2);
   assign empty_o = (count_q == 2'd0);
   assign head_o  = mem_q[rd_ptr_q];

   // A push into a full buffer is only accepted when the head leaves the same cycle.
   assign push_ok = push_i && (!full_o || pop_i);
   assign pop_ok  = pop_i && !empty_o;

   always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush_i) begin
         wr_ptr_d = 1'b0;
         rd_ptr_d = 1'b0;
         count_d  = 2'd0;
      end else begin
         if (push_ok) begin
            mem_d[wr_ptr_q] = data_i;
            wr_ptr_d        = ~wr_ptr_q;
         end
         if (pop_ok) begin
            rd_ptr_d = ~rd_ptr_q;
         end
         count_d = count_q + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         mem_q    <= '{default: '0};
         wr_ptr_q <= 1'b0;
         rd_ptr_q <= 1'b0;
         count_q  <= 2'd0;
      end else begin
         mem_q    <= mem_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

endmodule

// File: rtl/ifu.sv
// Instruction fetch unit: PC register, ROM address drive, and a buffered
// valid/ready hand-off of {pc, inst} to decode with redirect flush.
module ifu
   import ifu_pkg::*;
#(
   parameter logic [PORT_ADDR_WIDTH-1:0] RESET_PC = RESET_PC_ADDR,
   parameter logic [PORT_DATA_WIDTH-1:0] NOP_INST = INST_NOP
) (
   input  logic                       clk,
   input  logic                       rst_n,
   output logic [PORT_ADDR_WIDTH-1:0] ifu_pc_o,
   input  logic [PORT_DATA_WIDTH-1:0] ifu_rom_inst_i,
   input  logic                       ifu_hold_i,
   input  logic                       ifu_jump_en_i,
   input  logic [PORT_ADDR_WIDTH-1:0] ifu_jump_addr_i,
   output logic                       ifu_valid_o,
   input  logic                       ifu_ready_i,
   output logic [PORT_DATA_WIDTH-1:0] ifu_inst_o,
   output logic [PORT_ADDR_WIDTH-1:0] ifu_inst_pc_o
);

   logic [PORT_ADDR_WIDTH-1:0] pc_q, pc_d;
   logic                       enq, pop;
   logic                       fifo_full, fifo_empty;
   fetch_entry_t               tail_entry, head_entry;
   logic [ENTRY_WIDTH-1:0]     head_bits;

   assign ifu_pc_o    = pc_q;
   assign ifu_valid_o = !fifo_empty;

   // Redirect outranks both sides of the buffer; a pop frees a slot for a same-cycle enqueue.
   assign pop = ifu_valid_o && ifu_ready_i && !ifu_jump_en_i;
   assign enq = !ifu_jump_en_i && !ifu_hold_i && (!fifo_full || pop);

   always_comb begin
      tail_entry      = '0;
      tail_entry.pc   = pc_q;
      tail_entry.inst = ifu_rom_inst_i;
   end

   always_comb begin
      pc_d = pc_q;
      if (ifu_jump_en_i) begin
         pc_d = word_align(ifu_jump_addr_i);
      end else if (enq) begin
         pc_d = pc_incr(pc_q);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         pc_q <= RESET_PC;
      end else begin
         pc_q <= pc_d;
      end
   end

   ifu_fifo #(
      .WIDTH(ENTRY_WIDTH)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .push_i (enq),
      .pop_i  (pop),
      .flush_i(ifu_jump_en_i),
      .data_i (tail_entry),
      .full_o (fifo_full),
      .empty_o(fifo_empty),
      .head_o (head_bits)
   );

   assign head_entry = fetch_entry_t'(head_bits);

   always_comb begin
      ifu_inst_o    = NOP_INST;
      ifu_inst_pc_o = '0;
      if (ifu_valid_o) begin
         ifu_inst_o    = head_entry.inst;
         ifu_inst_pc_o = head_entry.pc;
      end
   end

endmodule

// File: tb/tb_ifu.sv
// Directed table-driven bench for ifu: each row drives one cycle of inputs and
// lists the outputs expected just after that cycle's rising edge.
module tb_ifu;

   logic        clk;
   logic        rst_n;
   logic [31:0] ifu_pc_o;
   logic [31:0] ifu_rom_inst_i;
   logic        ifu_hold_i;
   logic        ifu_jump_en_i;
   logic [31:0] ifu_jump_addr_i;
   logic        ifu_valid_o;
   logic        ifu_ready_i;
   logic [31:0] ifu_inst_o;
   logic [31:0] ifu_inst_pc_o;

   int n_checks = 0;
   int n_fail   = 0;

   typedef struct {
      logic        rst_n;
      logic        hold;
      logic        jump;
      logic [31:0] jaddr;
      logic        ready;
      logic        exp_valid;
      logic [31:0] exp_pc;
      logic [31:0] exp_ipc;
   } vec_t;

   vec_t vecs[$];

   ifu #(
      .RESET_PC(32'h0000_0000),
      .NOP_INST(32'h0000_0013)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .ifu_pc_o       (ifu_pc_o),
      .ifu_rom_inst_i (ifu_rom_inst_i),
      .ifu_hold_i     (ifu_hold_i),
      .ifu_jump_en_i  (ifu_jump_en_i),
      .ifu_jump_addr_i(ifu_jump_addr_i),
      .ifu_valid_o    (ifu_valid_o),
      .ifu_ready_i    (ifu_ready_i),
      .ifu_inst_o     (ifu_inst_o),
      .ifu_inst_pc_o  (ifu_inst_pc_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ROM contents are a fixed scramble of the address so inst and pc differ.
   function automatic logic [31:0] rom_fn(input logic [31:0] a);
      return a ^ 32'hC0DE_0000;
   endfunction

   always_comb ifu_rom_inst_i = rom_fn(ifu_pc_o);

   function automatic void add(input logic r, input logic h, input logic j,
                               input logic [31:0] ja, input logic rdy,
                               input logic v, input logic [31:0] pc,
                               input logic [31:0] ipc);
      vec_t t;
      t.rst_n = r; t.hold = h; t.jump = j; t.jaddr = ja; t.ready = rdy;
      t.exp_valid = v; t.exp_pc = pc; t.exp_ipc = ipc;
      vecs.push_back(t);
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check_outputs(input string tag, input logic v, input logic [31:0] pc,
                                input logic [31:0] ipc);
      check({tag, " valid"}, {31'd0, ifu_valid_o}, {31'd0, v});
      check({tag, " pc_o"}, ifu_pc_o, pc);
      check({tag, " inst_pc"}, ifu_inst_pc_o, v ? ipc : 32'h0);
      check({tag, " inst"}, ifu_inst_o, v ? rom_fn(ipc) : 32'h0000_0013);
   endtask

   initial begin
      rst_n = 1'b0; ifu_hold_i = 1'b0; ifu_jump_en_i = 1'b0;
      ifu_jump_addr_i = '0; ifu_ready_i = 1'b0;

      //  rst h  j  jaddr          rdy  v  pc_o           inst_pc
      add(0, 0, 0, 32'h0,         1,   0, 32'h0,         32'h0);        // reset
      add(0, 0, 0, 32'h0,         1,   0, 32'h0,         32'h0);
      add(1, 0, 0, 32'h0,         1,   1, 32'h4,         32'h0);        // stream
      add(1, 0, 0, 32'h0,         1,   1, 32'h8,         32'h4);
      add(1, 0, 0, 32'h0,         1,   1, 32'hC,         32'h8);
      add(1, 0, 0, 32'h0,         1,   1, 32'h10,        32'hC);
      add(0, 0, 0, 32'h0,         0,   0, 32'h0,         32'h0);        // ready low
      add(1, 0, 0, 32'h0,         0,   1, 32'h4,         32'h0);
      add(1, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0);
      add(1, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0);
      add(1, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0);
      add(1, 0, 0, 32'h0,         0,   1, 32'h8,         32'h0);
      add(1, 0, 0, 32'h0,         1,   1, 32'hC,         32'h4);        // release, no bubble
      add(1, 0, 0, 32'h0,         1,   1, 32'h10,        32'h8);
      add(1, 0, 0, 32'h0,         1,   1, 32'h14,        32'hC);
      add(1, 0, 1, 32'h103,       1,   0, 32'h100,       32'h0);        // jump
      add(1, 0, 0, 32'h0,         1,   1, 32'h104,       32'h100);
      add(1, 0, 0, 32'h0,         1,   1, 32'h108,       32'h104);
      add(1, 1, 1, 32'h200,       1,   0, 32'h200,       32'h0);        // jump + hold
      add(1, 1, 0, 32'h0,         1,   0, 32'h200,       32'h0);
      add(1, 1, 0, 32'h0,         1,   0, 32'h200,       32'h0);
      add(1, 0, 0, 32'h0,         1,   1, 32'h204,       32'h200);
      add(1, 0, 0, 32'h0,         1,   1, 32'h208,       32'h204);
      add(1, 1, 0, 32'h0,         1,   0, 32'h208,       32'h0);        // hold drains
      add(1, 0, 0, 32'h0,         1,   1, 32'h20C,       32'h208);
      add(1, 0, 0, 32'h0,         0,   1, 32'h210,       32'h208);      // fill to 2
      add(0, 0, 0, 32'h0,         0,   0, 32'h0,         32'h0);        // reset while full
      add(1, 0, 0, 32'h0,         1,   1, 32'h4,         32'h0);
      add(1, 0, 0, 32'h0,         1,   1, 32'h8,         32'h4);
      add(1, 0, 1, 32'hFFFF_FFFC, 1,   0, 32'hFFFF_FFFC, 32'h0);        // wrap
      add(1, 0, 0, 32'h0,         1,   1, 32'h0,         32'hFFFF_FFFC);
      add(1, 0, 0, 32'h0,         1,   1, 32'h4,         32'h0);
      add(1, 0, 0, 32'h0,         1,   1, 32'h8,         32'h4);

      foreach (vecs[i]) begin
         @(negedge clk);
         rst_n           = vecs[i].rst_n;
         ifu_hold_i      = vecs[i].hold;
         ifu_jump_en_i   = vecs[i].jump;
         ifu_jump_addr_i = vecs[i].jaddr;
         ifu_ready_i     = vecs[i].ready;
         @(posedge clk);
         #1;
         check_outputs($sformatf("row%0d", i), vecs[i].exp_valid, vecs[i].exp_pc,
                       vecs[i].exp_ipc);
      end

      // State now: head PC 4, PC 8, one entry. Ready must not reach outputs combinationally.
      @(negedge clk);
      ifu_ready_i = 1'b0;
      #1;
      check_outputs("ready_comb", 1'b1, 32'h8, 32'h4);
      @(posedge clk); #1;
      check_outputs("stall1", 1'b1, 32'hC, 32'h4);
      @(posedge clk); #1;
      check_outputs("stall2", 1'b1, 32'hC, 32'h4);
      // Jump with a full buffer and ready low: both stale words must vanish.
      @(negedge clk);
      ifu_jump_en_i = 1'b1; ifu_jump_addr_i = 32'h0000_4002;
      @(posedge clk); #1;
      check_outputs("jump_full", 1'b0, 32'h4000, 32'h0);
      @(negedge clk);
      ifu_jump_en_i = 1'b0; ifu_ready_i = 1'b1;
      @(posedge clk); #1;
      check_outputs("after_jump", 1'b1, 32'h4004, 32'h4000);
      @(posedge clk); #1;
      check_outputs("after_jump2", 1'b1, 32'h4008, 32'h4004);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

endmodule
